// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-timing derivation and FSM state encodings,
// used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned NS_PER_S = 32'd1_000_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per line bit, computed from integer bit and clock periods in ns.
    function automatic int unsigned cycles_per_bit(input int unsigned bit_rate,
                                                   input int unsigned clk_hz);
        return (NS_PER_S / bit_rate) / (NS_PER_S / clk_hz);
    endfunction

    function automatic int unsigned half_bit(input int unsigned bit_rate,
                                             input int unsigned clk_hz);
        return cycles_per_bit(bit_rate, clk_hz) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous receive pin; resets to the idle
// (high) line level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, mid-bit sampling of LSB-first data, stop
// bit check, single holding register with valid/overrun/break reporting.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic                    uart_rx_read,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_overrun,
    output logic                    uart_rx_break
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(BIT_RATE, CLK_HZ);
    localparam int unsigned HALF_BIT       = half_bit(BIT_RATE, CLK_HZ);
    localparam int unsigned CNT_W          = 1 + $clog2(CYCLES_PER_BIT);
    localparam int unsigned IDX_W          = $clog2(PAYLOAD_BITS + 1);

    uart_state_e             state, state_next;
    logic [CNT_W-1:0]        counter, counter_next;
    logic [IDX_W-1:0]        bit_idx, bit_idx_next;
    logic [PAYLOAD_BITS-1:0] shift, shift_next;
    logic [PAYLOAD_BITS-1:0] data_next;
    logic                    valid_next, overrun_next, break_next;
    logic                    rxd_s, rxd_q;
    logic                    fall_c, read_ok_c, stop_ok_c, half_done_c, bit_done_c;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    // A frame only starts on a genuine high-to-low transition, never on a held-low line.
    assign fall_c      = rxd_q && !rxd_s;
    assign read_ok_c   = uart_rx_read && uart_rx_valid;
    // With no stop bits configured the stop slot is not validated.
    assign stop_ok_c   = rxd_s || (STOP_BITS == 0);
    // Counter value 0 is the first cycle in a state, so N cycles end at N-1.
    assign half_done_c = (counter == CNT_W'(HALF_BIT - 1));
    assign bit_done_c  = (counter == CNT_W'(CYCLES_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            counter         <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            rxd_q           <= 1'b1;
            uart_rx_data    <= '0;
            uart_rx_valid   <= 1'b0;
            uart_rx_overrun <= 1'b0;
            uart_rx_break   <= 1'b0;
        end else begin
            state           <= state_next;
            counter         <= counter_next;
            bit_idx         <= bit_idx_next;
            shift           <= shift_next;
            rxd_q           <= rxd_s;
            uart_rx_data    <= data_next;
            uart_rx_valid   <= valid_next;
            uart_rx_overrun <= overrun_next;
            uart_rx_break   <= break_next;
        end
    end

    always_comb begin
        state_next   = state;
        counter_next = counter;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = uart_rx_data;
        valid_next   = uart_rx_valid;
        overrun_next = uart_rx_overrun;
        break_next   = 1'b0;

        if (read_ok_c) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end

        if (!uart_rx_en) begin
            state_next   = IDLE;
            counter_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    counter_next = '0;
                    if (fall_c) begin
                        state_next = START;
                    end
                end
                START: begin
                    counter_next = counter + CNT_W'(1);
                    if (half_done_c) begin
                        counter_next = '0;
                        bit_idx_next = '0;
                        state_next   = rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    counter_next = counter + CNT_W'(1);
                    if (bit_done_c) begin
                        counter_next = '0;
                        shift_next   = shift >> 1;
                        shift_next[PAYLOAD_BITS-1] = rxd_s;
                        bit_idx_next = bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    counter_next = counter + CNT_W'(1);
                    if (bit_done_c) begin
                        counter_next = '0;
                        state_next   = IDLE;
                        if (stop_ok_c) begin
                            data_next  = shift;
                            valid_next = 1'b1;
                            if (uart_rx_valid && !uart_rx_read) begin
                                overrun_next = 1'b1;
                            end
                        end else if (shift == '0) begin
                            break_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: frame table plus hand
// sequences for latency, glitch, break, reset and enable corner cases.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_read;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_overrun;
    logic       uart_rx_break;

    int checks = 0;
    int errors = 0;
    int brk_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ov;
        int         exp_brk;
    } vec_t;

    vec_t vecs[10];

    uart_rx #(
        .BIT_RATE     (100_000),
        .CLK_HZ       (1_000_000),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rxd        (uart_rxd),
        .uart_rx_en      (uart_rx_en),
        .uart_rx_read    (uart_rx_read),
        .uart_rx_valid   (uart_rx_valid),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_overrun (uart_rx_overrun),
        .uart_rx_break   (uart_rx_break)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_rx_break) brk_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [7:0] b;
        b = d;
        uart_rxd = 1'b0;
        cycles(10);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cycles(10);
        end
        uart_rxd = stop;
        cycles(10);
        uart_rxd = 1'b1;
    endtask

    task automatic read_pulse();
        uart_rx_read = 1'b1;
        cycles(1);
        uart_rx_read = 1'b0;
    endtask

    initial begin
        int lat;
        logic [9:0] fr;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 0};
        vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1};
        vecs[4] = '{8'h7E, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 0};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 0};
        vecs[8] = '{8'h0F, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 0};
        vecs[9] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b1, 0};

        reset = 1'b1;
        uart_rxd = 1'b1;
        uart_rx_en = 1'b1;
        uart_rx_read = 1'b0;
        cycles(3);
        check("rst_valid", 32'(uart_rx_valid), 32'd0);
        check("rst_data", 32'(uart_rx_data), 32'd0);
        check("rst_overrun", 32'(uart_rx_overrun), 32'd0);
        check("rst_break", 32'(uart_rx_break), 32'd0);
        reset = 1'b0;
        cycles(5);

        // Frame table; frames follow each other with only a short idle gap.
        for (int i = 0; i < 10; i++) begin
            brk_cnt = 0;
            send_frame(vecs[i].data, vecs[i].stop);
            cycles(4);
            check($sformatf("v%0d_valid", i), 32'(uart_rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data", i), 32'(uart_rx_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_overrun", i), 32'(uart_rx_overrun), 32'(vecs[i].exp_ov));
            check($sformatf("v%0d_break", i), 32'(brk_cnt), 32'(vecs[i].exp_brk));
            if (vecs[i].rd) begin
                read_pulse();
                check($sformatf("v%0d_rd_valid", i), 32'(uart_rx_valid), 32'd0);
                check($sformatf("v%0d_rd_overrun", i), 32'(uart_rx_overrun), 32'd0);
            end
        end

        // Start-edge to valid latency for 0x55.
        fr = {1'b1, 8'h55, 1'b0};
        lat = 0;
        for (int c = 0; c < 120; c++) begin
            uart_rxd = (c < 100) ? fr[c / 10] : 1'b1;
            cycles(1);
            if (uart_rx_valid && lat == 0) lat = c + 1;
        end
        checks++;
        if (lat < 96 || lat > 100) begin
            errors++;
            $display("FAIL latency actual=%0d expected=96..100", lat);
        end
        check("lat_data", 32'(uart_rx_data), 32'h55);
        check("lat_overrun", 32'(uart_rx_overrun), 32'd0);
        read_pulse();

        // Short low glitch is rejected, next frame still received.
        brk_cnt = 0;
        uart_rxd = 1'b0;
        cycles(3);
        uart_rxd = 1'b1;
        cycles(30);
        check("glitch_valid", 32'(uart_rx_valid), 32'd0);
        check("glitch_break", 32'(brk_cnt), 32'd0);
        send_frame(8'h81, 1'b1);
        cycles(4);
        check("post_glitch_valid", 32'(uart_rx_valid), 32'd1);
        check("post_glitch_data", 32'(uart_rx_data), 32'h81);

        // Line held low for 12 bit times: exactly one break, held byte untouched.
        brk_cnt = 0;
        uart_rxd = 1'b0;
        cycles(120);
        uart_rxd = 1'b1;
        cycles(30);
        check("hold_low_break", 32'(brk_cnt), 32'd1);
        check("hold_low_valid", 32'(uart_rx_valid), 32'd1);
        check("hold_low_data", 32'(uart_rx_data), 32'h81);
        check("hold_low_overrun", 32'(uart_rx_overrun), 32'd0);
        read_pulse();

        // Reset during data bit 4 of 0xFF.
        uart_rxd = 1'b0;
        cycles(10);
        uart_rxd = 1'b1;
        cycles(45);
        reset = 1'b1;
        cycles(3);
        check("midrst_data", 32'(uart_rx_data), 32'd0);
        check("midrst_valid", 32'(uart_rx_valid), 32'd0);
        reset = 1'b0;
        cycles(60);
        check("after_rst_valid", 32'(uart_rx_valid), 32'd0);
        send_frame(8'h12, 1'b1);
        cycles(4);
        check("after_rst_rx_valid", 32'(uart_rx_valid), 32'd1);
        check("after_rst_rx_data", 32'(uart_rx_data), 32'h12);
        read_pulse();

        // Enable dropped mid-frame discards the frame.
        brk_cnt = 0;
        uart_rxd = 1'b0;
        cycles(10);
        uart_rxd = 1'b1;
        cycles(35);
        uart_rx_en = 1'b0;
        cycles(10);
        uart_rx_en = 1'b1;
        cycles(60);
        check("en_drop_valid", 32'(uart_rx_valid), 32'd0);
        check("en_drop_data", 32'(uart_rx_data), 32'h12);
        check("en_drop_break", 32'(brk_cnt), 32'd0);
        send_frame(8'h5A, 1'b1);
        cycles(4);
        check("en_back_valid", 32'(uart_rx_valid), 32'd1);
        check("en_back_data", 32'(uart_rx_data), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
